// File: rtl/sm_input_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sm_input_debounce_pkg : board timing constants and debounce helpers  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package sm_input_debounce_pkg;

   localparam int unsigned BOARD_CLK_HZ          = 100_000_000;
   localparam int unsigned DEBOUNCE_MS           = 10;
   localparam int unsigned DEFAULT_STABLE_CYCLES = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int unsigned DEFAULT_CNT_W         = 20;

   // True when a counter of width w can hold the terminal count stable-1.
   function automatic bit cnt_width_ok(input int unsigned stable, input int unsigned w);
      return (w < 32) ? ((64'd1 << w) > 64'(stable - 1)) : 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sm_debounce_bit.sv
// ---------------------------------------------------------------------------
// sm_debounce_bit : one-bit synchronizer, stability counter and edge pulses  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sm_debounce_bit
   import sm_input_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic change_d_o
);

   localparam logic [CNT_W-1:0] C_TERM = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   logic             sync0_q, sync1_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync0_q <= din_i;
         sync1_q <= sync0_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Any return to the committed level restarts the stability window.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync1_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == C_TERM) begin
         level_d = sync1_q;
         cnt_d   = '0;
         rise_d  = sync1_q;
         fall_d  = ~sync1_q;
      end else begin
         cnt_d = cnt_q + C_ONE;
      end
   end

   assign level_o    = level_q;
   assign rise_o     = rise_q;
   assign fall_o     = fall_q;
   assign change_d_o = rise_d | fall_d;

endmodule

`default_nettype wire

// File: rtl/sm_input_debounce.sv
// ---------------------------------------------------------------------------
// sm_input_debounce : multi-bit board input conditioner with edge pulses  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sm_input_debounce
   import sm_input_debounce_pkg::*;
#(
   parameter int unsigned       WIDTH         = 5,
   parameter int unsigned       STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int unsigned       CNT_W         = DEFAULT_CNT_W,
   parameter logic [WIDTH-1:0]  INVERT        = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   generate
      if (STABLE_CYCLES < 1) begin : g_bad_stable
         $error("sm_input_debounce: STABLE_CYCLES must be at least 1");
      end
      if (!cnt_width_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_cnt_w
         $error("sm_input_debounce: CNT_W too narrow for STABLE_CYCLES");
      end
   endgenerate

   logic [WIDTH-1:0] w_masked;
   logic [WIDTH-1:0] w_change_d;
   logic             any_change_q;

   assign w_masked = raw_in ^ INVERT;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         sm_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
         ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .din_i      (w_masked[i]),
            .level_o    (level_out[i]),
            .rise_o     (rise_pulse[i]),
            .fall_o     (fall_pulse[i]),
            .change_d_o (w_change_d[i])
         );
      end
   endgenerate

   // Registered from the pulse next-state so it lines up with the pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         any_change_q <= 1'b0;
      end else begin
         any_change_q <= |w_change_d;
      end
   end

   assign any_change = any_change_q;

endmodule

`default_nettype wire

// File: tb/tb_sm_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_sm_input_debounce : scoreboard bench for sm_input_debounce  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sm_input_debounce;

   localparam int S   = 4;
   localparam int LAT = S + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] raw_in = 5'b10000;
   logic [4:0] level_out, rise_pulse, fall_pulse;
   logic       any_change;

   sm_input_debounce #(
      .WIDTH         (5),
      .STABLE_CYCLES (S),
      .CNT_W         (3),
      .INVERT        (5'b10000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .any_change (any_change)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [4:0] lvl;
      logic [4:0] rise;
      logic [4:0] fall;
   } exp_t;

   exp_t       q[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [4:0] exp_lvl = 5'b00000;

   function automatic void check(string name, logic [4:0] act, logic [4:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, req);
      end
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Input change just applied is sampled on the next edge; commit lands LAT edges later.
   task automatic expect_commit(input logic [4:0] new_lvl);
      exp_t e;
      e.cyc  = cyc + LAT;
      e.lvl  = new_lvl;
      e.rise = new_lvl & ~exp_lvl;
      e.fall = ~new_lvl & exp_lvl;
      q.push_back(e);
      exp_lvl = new_lvl;
   endtask

   logic [4:0] mon_lvl = 5'b00000;

   always @(negedge clk) begin
      if (rst) begin
         mon_lvl = 5'b00000;
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
         exp_t e;
         e = q.pop_front();
         mon_lvl = e.lvl;
         check("evt_level", level_out, e.lvl);
         check("evt_rise", rise_pulse, e.rise);
         check("evt_fall", fall_pulse, e.fall);
         check("evt_any", {4'b0, any_change}, 5'b00001);
      end else begin
         check("idle_level", level_out, mon_lvl);
         check("idle_pulses", rise_pulse | fall_pulse, 5'b00000);
         check("idle_any", {4'b0, any_change}, 5'b00000);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      step(2);
      check("rst_level", level_out, 5'b00000);
      check("rst_rise", rise_pulse, 5'b00000);
      check("rst_fall", fall_pulse, 5'b00000);
      check("rst_any", {4'b0, any_change}, 5'b00000);
      rst = 1'b0;
      step(20);

      // Single clean rise on bit 0
      raw_in[0] = 1'b1;
      expect_commit(5'b00001);
      step(10);

      // Bouncing bit 1, then a clean hold
      for (int k = 0; k < 20; k++) begin
         raw_in[1] = ~raw_in[1];
         step(2);
      end
      raw_in[1] = 1'b1;
      expect_commit(5'b00011);
      step(10);

      // Active-low bit 4: press then release
      raw_in[4] = 1'b0;
      expect_commit(5'b10011);
      step(10);
      raw_in[4] = 1'b1;
      expect_commit(5'b00011);
      step(10);

      // Simultaneous rise on bits 2 and 3
      raw_in[3:2] = 2'b11;
      expect_commit(5'b01111);
      step(10);

      // Fall on bit 0, then reset in the middle of the next rise's count
      raw_in[0] = 1'b0;
      expect_commit(5'b01110);
      step(10);
      raw_in[0] = 1'b1;
      step(5);
      rst = 1'b1;
      #1;
      check("async_rst_level", level_out, 5'b00000);
      check("async_rst_rise", rise_pulse, 5'b00000);
      check("async_rst_fall", fall_pulse, 5'b00000);
      check("async_rst_any", {4'b0, any_change}, 5'b00000);
      exp_lvl = 5'b00000;
      step(2);
      rst = 1'b0;
      expect_commit(5'b01111);
      step(12);

      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d expected events never seen, expected 0", q.size());
      end
      check("final_level", level_out, 5'b01111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
